// File: rtl/ysyx_23060286_ifu_pkg.sv
// rtl/ysyx_23060286_ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_23060286_ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } ifu_state_e;

  localparam int INST_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060286_ifu_fifo.sv
// rtl/ysyx_23060286_ifu_fifo.sv - synchronous FIFO with clear; head read directly from storage flops
module ysyx_23060286_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // a pop frees the slot a same-cycle push lands in, so push is allowed even when full
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || clr)) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ysyx_23060286_ifu.sv
// rtl/ysyx_23060286_ifu.sv - handshaked fetch front end with redirect flush and decode queue
// Optional performance counters: define YSYX_23060286_IFU_PERF_EN.
module ysyx_23060286_ifu
  import ysyx_23060286_ifu_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                INST_W   = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   inst_snpc
`ifdef YSYX_23060286_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e          state_q;
  logic [XLEN-1:0]     fetch_pc_q;
  logic [XLEN-1:0]     redirect_pc_al;
  logic                req_fire, rsp_push, q_pop;
  logic                q_full, q_empty;
  logic [CW-1:0]       q_count;
  logic [XLEN+INST_W-1:0] q_head;
  logic                unused_full;

  assign redirect_pc_al = redirect_pc & ~XLEN'(3);

  assign imem_req_valid = !rst && (state_q == S_REQ) && (q_count < CW'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_push       = !rst && (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

  assign inst_valid = !rst && !q_empty && !redirect_valid;
  assign q_pop      = inst_valid && inst_ready;
  assign inst_pc    = q_head[XLEN+INST_W-1:INST_W];
  assign inst_out   = q_head[INST_W-1:0];
  assign inst_snpc  = inst_pc + XLEN'(INST_BYTES);
  assign unused_full = q_full;

  ysyx_23060286_ifu_fifo #(
    .WIDTH(XLEN + INST_W),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect_valid),
    .push     (rsp_push),
    .push_data({fetch_pc_q, imem_rsp_data}),
    .pop      (q_pop),
    .pop_data (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      // a response racing the redirect is dropped; an outstanding one must be drained in S_FLUSH
      fetch_pc_q <= redirect_pc_al;
      case (state_q)
        S_WAIT, S_FLUSH: state_q <= imem_rsp_valid ? S_REQ : S_FLUSH;
        default:         state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ:   if (req_fire) state_q <= S_WAIT;
        S_WAIT:  if (imem_rsp_valid) begin
                   fetch_pc_q <= fetch_pc_q + XLEN'(INST_BYTES);
                   state_q    <= S_REQ;
                 end
        S_FLUSH: if (imem_rsp_valid) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

`ifdef YSYX_23060286_IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (rsp_push)       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!inst_valid)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// tb/tb_ysyx_23060286_ifu.sv - scoreboard bench for the fetch unit
module tb_ysyx_23060286_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out, inst_pc, inst_snpc;
`ifdef YSYX_23060286_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_23060286_ifu dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_snpc     (inst_snpc)
`ifdef YSYX_23060286_IFU_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic        mem_ready = 1'b1;
  logic        cons_ready = 1'b1;
  int          rsp_lat = 1;
  logic        rst_now = 1'b1;
  logic        redir_now = 1'b0;
  logic [31:0] redir_pc_now = '0;
  int          rsp_timer = 0;
  logic [31:0] rsp_addr = '0;
  logic [31:0] model_pc = RST_PC;
  logic [63:0] exp_q [$];

  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_req_addr, s_inst_pc, s_inst_snpc, s_inst_out;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 | {a[13:2], 20'h0};
  endfunction

  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    rst            = rst_now;
    redirect_valid = redir_now;
    redirect_pc    = redir_pc_now;
    imem_req_ready = mem_ready;
    inst_ready     = cons_ready;
    imem_rsp_valid = (rsp_timer == 1);
    imem_rsp_data  = (rsp_timer == 1) ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst_snpc  = inst_snpc;
    s_inst_out   = inst_out;
    if (rst_now) begin
      exp_q.delete();
      model_pc  = RST_PC;
      rsp_timer = 0;
    end else begin
      if (s_inst_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stale_inst: got pc %h inst %h, required no valid instruction", s_inst_pc, s_inst_out);
        end else begin
          e = exp_q[0];
          if (s_inst_pc !== e[63:32] || s_inst_out !== e[31:0] || s_inst_snpc !== e[63:32] + 32'd4) begin
            fails++;
            $display("FAIL head: got pc %h inst %h snpc %h, required pc %h inst %h snpc %h",
                     s_inst_pc, s_inst_out, s_inst_snpc, e[63:32], e[31:0], e[63:32] + 32'd4);
          end
          if (cons_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (redir_now) begin
        tests++;
        if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin
          fails++;
          $display("FAIL redirect_mask: got req_valid %b inst_valid %b, required 0 0", s_req_valid, s_inst_valid);
        end
      end
      if (rsp_timer > 0) rsp_timer--;
      if (redir_now) begin
        exp_q.delete();
        model_pc = redir_pc_now & ~32'h3;
      end else if (s_req_valid && mem_ready) begin
        tests++;
        if (s_req_addr !== model_pc) begin
          fails++;
          $display("FAIL req_addr: got %h, required %h", s_req_addr, model_pc);
        end
        exp_q.push_back({model_pc, mem_word(model_pc)});
        rsp_timer = rsp_lat;
        rsp_addr  = s_req_addr;
        model_pc  = model_pc + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_now = 1'b1; redir_now = 1'b0; mem_ready = 1'b1; cons_ready = 1'b1; rsp_lat = 1;
    cycle(); cycle();
    rst_now = 1'b0;
  endtask

  task automatic test_reset();
    rst_now = 1'b1; redir_now = 1'b0; mem_ready = 1'b1; cons_ready = 1'b1; rsp_lat = 1;
    cycle(); cycle();
    tests++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got req_valid %b inst_valid %b, required 0 0", s_req_valid, s_inst_valid);
    end
    rst_now = 1'b0;
    cycle();
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL first_req: got valid %b addr %h, required 1 80000000", s_req_valid, s_req_addr);
    end
    cycle();
    tests++;
    if (s_inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL early_inst: got inst_valid %b, required 0", s_inst_valid);
    end
    cycle();
    tests++;
    if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'h8000_0000 || s_inst_snpc !== 32'h8000_0004 || s_inst_out !== 32'h0000_0013) begin
      fails++;
      $display("FAIL first_inst: got valid %b pc %h snpc %h inst %h, required 1 80000000 80000004 00000013",
               s_inst_valid, s_inst_pc, s_inst_snpc, s_inst_out);
    end
  endtask

  task automatic test_queue_full();
    do_reset();
    cons_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i >= 4) begin
        tests++;
        if (s_req_valid !== 1'b0) begin
          fails++;
          $display("FAIL full_req_blocked: cycle %0d got req_valid %b, required 0", i, s_req_valid);
        end
      end
    end
    cons_ready = 1'b1;
    cycle();
    tests++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1 || s_inst_pc !== 32'h8000_0000) begin
      fails++;
      $display("FAIL full_pop: got req_valid %b inst_valid %b pc %h, required 0 1 80000000", s_req_valid, s_inst_valid, s_inst_pc);
    end
    cons_ready = 1'b0;
    cycle();
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0008 || s_inst_pc !== 32'h8000_0004) begin
      fails++;
      $display("FAIL full_resume: got req_valid %b addr %h head %h, required 1 80000008 80000004", s_req_valid, s_req_addr, s_inst_pc);
    end
    cons_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_req_stall();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
        fails++;
        $display("FAIL req_hold: cycle %0d got valid %b addr %h, required 1 80000000", i, s_req_valid, s_req_addr);
      end
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    cons_ready = 1'b0;
    cycle(); cycle();
    rsp_lat = 3;
    cycle();
    tests++;
    if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'h8000_0000) begin
      fails++;
      $display("FAIL rw_before: got inst_valid %b pc %h, required 1 80000000", s_inst_valid, s_inst_pc);
    end
    redir_now = 1'b1; redir_pc_now = 32'h8000_0103;
    cycle();
    redir_now = 1'b0;
    cycle();
    tests++;
    if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rw_cleared: got inst_valid %b req_valid %b, required 0 0", s_inst_valid, s_req_valid);
    end
    cycle();
    tests++;
    if (s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rw_flush_wait: got req_valid %b, required 0", s_req_valid);
    end
    rsp_lat = 1;
    cycle();
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0100) begin
      fails++;
      $display("FAIL rw_new_req: got valid %b addr %h, required 1 80000100", s_req_valid, s_req_addr);
    end
    cycle(); cycle();
    tests++;
    if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'h8000_0100) begin
      fails++;
      $display("FAIL rw_new_inst: got valid %b pc %h, required 1 80000100", s_inst_valid, s_inst_pc);
    end
    cons_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    cycle();
    redir_now = 1'b1; redir_pc_now = 32'h8000_0200;
    cycle();
    redir_now = 1'b0;
    cycle();
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0200 || s_inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rr_next: got req_valid %b addr %h inst_valid %b, required 1 80000200 0", s_req_valid, s_req_addr, s_inst_valid);
    end
    cycle(); cycle();
    tests++;
    if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'h8000_0200) begin
      fails++;
      $display("FAIL rr_inst: got valid %b pc %h, required 1 80000200", s_inst_valid, s_inst_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redir_now = 1'b1; redir_pc_now = 32'hFFFF_FFFC;
    cycle();
    redir_now = 1'b0;
    cycle();
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_req: got valid %b addr %h, required 1 fffffffc", s_req_valid, s_req_addr);
    end
    cycle(); cycle();
    tests++;
    if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'hFFFF_FFFC || s_inst_snpc !== 32'h0 || s_req_addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_inst: got valid %b pc %h snpc %h next addr %h, required 1 fffffffc 00000000 00000000",
               s_inst_valid, s_inst_pc, s_inst_snpc, s_req_addr);
    end
    cycle(); cycle();
    tests++;
    if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'h0 || s_inst_snpc !== 32'h4) begin
      fails++;
      $display("FAIL wrap_second: got valid %b pc %h snpc %h, required 1 00000000 00000004", s_inst_valid, s_inst_pc, s_inst_snpc);
    end
  endtask

  task automatic test_back_to_back();
    int start_pops;
    do_reset();
    start_pops = pops;
    for (int i = 0; i < 400; i++) begin
      mem_ready    = ($urandom_range(0, 3) != 0);
      cons_ready   = ($urandom_range(0, 2) != 0);
      rsp_lat      = $urandom_range(1, 3);
      redir_now    = ($urandom_range(0, 19) == 0);
      redir_pc_now = $urandom;
      cycle();
    end
    redir_now = 1'b0;
    tests++;
    if (pops - start_pops < 20) begin
      fails++;
      $display("FAIL b2b_progress: got %0d instructions consumed, required at least 20", pops - start_pops);
    end
  endtask

  initial begin
    test_reset();
    test_queue_full();
    test_req_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060286_ifu.md
Name: ysyx_23060286_ifu

Overview:
Parametrised instruction fetch unit. Replaces the single-cycle PC register, static-next-PC adder and PC mux with a handshaked front end. Holds the fetch PC and issues one request at a time to instruction memory over valid/ready. Buffers returned instructions in a DEPTH-entry queue toward decode and accepts redirects (branch/jump/jalr) from execute, discarding wrong-path fetches.

Parameters:
XLEN, 32, width of PC and addresses
INST_W, 32, instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset (XLEN bits)
DEPTH, 2, instruction queue entries; power of two, >=2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response data valid (single cycle)
imem_rsp_data  in  INST_W  fetched instruction
inst_valid  out  1  queue head valid toward decode
inst_ready  in  1  decode consumes head
inst_out  out  INST_W  head instruction
inst_pc  out  XLEN  head PC
inst_snpc  out  XLEN  inst_pc + 4, mod 2^XLEN

Behaviour:
- FSM states: S_REQ, S_WAIT, S_FLUSH. At most one outstanding request.
- Reset (rst=1 at edge): fetch_pc=RESET_PC, state=S_REQ, queue empty. While rst=1, imem_req_valid=0 and inst_valid=0. First request is asserted in the first cycle with rst=0.
- imem_req_valid = (state==S_REQ) && queue count<DEPTH && !redirect_valid. imem_req_addr=fetch_pc. Address is held stable while valid && !ready.
- S_REQ: req handshake -> S_WAIT.
- S_WAIT: imem_rsp_valid -> push {fetch_pc, imem_rsp_data}; fetch_pc += 4 (wraps at 2^XLEN); -> S_REQ. A free slot is guaranteed because the slot was checked at issue.
- S_FLUSH: imem_rsp_valid -> discard data, -> S_REQ.
- Redirect has highest priority in every state:
  - Queue is cleared at the edge.
  - inst_valid is forced to 0 in the redirect cycle, so no dequeue occurs.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Next state: S_WAIT without rsp -> S_FLUSH. S_WAIT or S_FLUSH with rsp_valid in the same cycle -> rsp dropped, S_REQ. S_FLUSH without rsp -> stay S_FLUSH. S_REQ -> S_REQ (req_valid was masked, no issue).
- Queue: registered outputs. inst_valid = count!=0 && !redirect_valid. Pop on inst_valid && inst_ready. Push and pop in the same cycle are legal at any count.
- Latency: request accepted at cycle T, rsp at T+1, inst_valid at T+2 at the earliest. Steady-state throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- imem_rsp_valid outside S_WAIT/S_FLUSH is illegal; it is ignored.
- Reset mid-transaction abandons any in-flight response; the next rsp_valid after reset falls in S_REQ and is ignored.

Optional Feature:
YSYX_23060286_IFU_PERF_EN:
- Defined: adds outputs perf_fetch_cnt[31:0] (increments per pushed instruction), perf_stall_cnt[31:0] (increments each cycle inst_valid=0 and rst=0) and perf_flush_cnt[31:0] (increments per redirect). All counters clear on rst and wrap.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ysyx_23060286_ifu_pkg: FSM state enum (2-bit), INST_BYTES=4 constant, default RESET_PC constant.
- Sub-module ysyx_23060286_ifu_fifo: generic synchronous FIFO with a clear input. Parameters WIDTH=XLEN+INST_W and DEPTH. Ports: push, pop, clr, full, empty, count.

Test Plan:
- Reset release, imem always ready, rsp one cycle later with data 0x00000013 -> first req addr 0x80000000; inst_valid with inst_pc=0x80000000 and inst_snpc=0x80000004 two cycles after accept.
- inst_ready=0, DEPTH=2 -> two instructions queued (0x80000000, 0x80000004); imem_req_valid stays 0 with addr 0x80000008 pending until one pop.
- imem_req_ready low for 3 cycles -> imem_req_valid held high, imem_req_addr stable at 0x80000000 throughout.
- redirect_valid with redirect_pc=0x80000103 while in S_WAIT -> queue empty next cycle; late response discarded (S_FLUSH); next req addr 0x80000100; no stale inst ever presented.
- redirect in the same cycle as imem_rsp_valid -> data dropped; S_REQ entered directly; next req issued the following cycle.
- Redirect to 0xFFFFFFFC with XLEN=32 -> fetch 0xFFFFFFFC, then 0x00000000; inst_snpc=0x00000000 for the first.
